// File: rtl/ws281x_frame_seq.sv
// ws281x_frame_seq: reads a frame of pixels from a synchronous pixel RAM and
// feeds them MSB-first, one bit per handshake, to the WS281x bit encoder.
// The next pixel is prefetched while the current one is shifting out so the
// bit stream has no gap at pixel boundaries. After the final bit the line is
// held idle for the latch interval, then done_o pulses.
module ws281x_frame_seq #(
   parameter int unsigned PIX_W  = 24,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned RST_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [ADDR_W:0]   pix_cnt_i,
   input  logic [RST_W-1:0]  rst_cnt_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [PIX_W-1:0]  rd_data_i,
   output logic              bit_vld_o,
   output logic              bit_data_o,
   input  logic              bit_rdy_i,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned      IDX_W   = $clog2(PIX_W);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PIX_W - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_LATCH = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]       state_q,   state_d;
   logic [ADDR_W:0]  pix_cnt_q, pix_cnt_d;
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [ADDR_W:0]  pix_idx_q, pix_idx_d;
   logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [PIX_W-1:0] shift_q,   shift_d;
   logic [PIX_W-1:0] pf_q,      pf_d;
   logic             pf_pend_q, pf_pend_d;
   logic             first_q,   first_d;
   logic [RST_W-1:0] lat_cnt_q, lat_cnt_d;

   logic [ADDR_W:0]  pix_next;
   logic             more_pix;
   logic             pf_rd;
   logic [RST_W:0]   lat_next;

   // Output decode and prefetch read request, all derived from current state.
   always_comb begin
      pix_next   = pix_idx_q + (ADDR_W+1)'(1);
      more_pix   = (pix_next < pix_cnt_q);
      lat_next   = {1'b0, lat_cnt_q} + (RST_W+1)'(1);
      pf_rd      = (state_q == S_WAIT) && first_q && (bit_idx_q == IDX_TOP) && more_pix;
      rd_en_o    = (state_q == S_FETCH) || pf_rd;
      rd_addr_o  = pf_rd ? pix_next[ADDR_W-1:0] : '0;
      bit_vld_o  = (state_q == S_SEND);
      bit_data_o = ((state_q == S_SEND) || (state_q == S_WAIT)) ? shift_q[PIX_W-1] : 1'b0;
      // busy covers the accepting cycle itself, so it is not purely registered
      busy_o     = (state_q != S_IDLE) || start_i;
      done_o     = (state_q == S_DONE);
   end

   // Next-state, counter, shift-register and prefetch computation.
   always_comb begin
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      rst_cnt_d = rst_cnt_q;
      pix_idx_d = pix_idx_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      first_d   = 1'b0;
      pf_pend_d = pf_rd;
      pf_d      = pf_pend_q ? rd_data_i : pf_q;
      lat_cnt_d = '0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               pix_cnt_d = pix_cnt_i;
               rst_cnt_d = rst_cnt_i;
               state_d   = (pix_cnt_i != '0) ? S_FETCH : S_LATCH;
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            shift_d   = rd_data_i;
            bit_idx_d = IDX_TOP;
            pix_idx_d = '0;
            state_d   = S_SEND;
         end
         S_SEND: begin
            first_d = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bit_rdy_i) begin
               if (bit_idx_q != '0) begin
                  shift_d   = {shift_q[PIX_W-2:0], 1'b0};
                  bit_idx_d = bit_idx_q - IDX_W'(1);
                  state_d   = S_SEND;
               end else if (more_pix) begin
                  shift_d   = pf_q;
                  bit_idx_d = IDX_TOP;
                  pix_idx_d = pix_next;
                  state_d   = S_SEND;
               end else begin
                  state_d = S_LATCH;
               end
            end
         end
         S_LATCH: begin
            // a zero interval still spends one cycle here
            lat_cnt_d = lat_next[RST_W-1:0];
            if (lat_next >= {1'b0, rst_cnt_q}) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         pix_cnt_q <= '0;
         rst_cnt_q <= '0;
         pix_idx_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         pf_q      <= '0;
         pf_pend_q <= 1'b0;
         first_q   <= 1'b0;
         lat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         rst_cnt_q <= rst_cnt_d;
         pix_idx_q <= pix_idx_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         pf_q      <= pf_d;
         pf_pend_q <= pf_pend_d;
         first_q   <= first_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

endmodule

// File: tb/tb_ws281x_frame_seq.sv
// Scoreboard bench for ws281x_frame_seq: stimulus pushes expected reads, bits
// and done timing into queues; a negedge monitor pops and compares.
module tb_ws281x_frame_seq;
   localparam int PIX_W  = 24;
   localparam int ADDR_W = 8;
   localparam int RST_W  = 16;

   logic              clk_i = 1'b0;
   logic              rst_n_i = 1'b0;
   logic              start_i = 1'b0;
   logic [ADDR_W:0]   pix_cnt_i = '0;
   logic [RST_W-1:0]  rst_cnt_i = '0;
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [PIX_W-1:0]  rd_data_i = '0;
   logic              bit_vld_o;
   logic              bit_data_o;
   logic              bit_rdy_i = 1'b0;
   logic              busy_o;
   logic              done_o;

   ws281x_frame_seq #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .RST_W(RST_W)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
      .pix_cnt_i(pix_cnt_i), .rst_cnt_i(rst_cnt_i),
      .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
      .bit_vld_o(bit_vld_o), .bit_data_o(bit_data_o), .bit_rdy_i(bit_rdy_i),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { int lat; int busy; } done_t;

   logic [PIX_W-1:0]  ram [0:255];
   logic [ADDR_W-1:0] exp_addr [$];
   bit                exp_bits [$];
   done_t             exp_done [$];

   int checks = 0, fails = 0;
   int cyc = 0, rdy_due = -100, enc_lat = 10;
   bit dbl = 1'b0;
   int strobe_cnt = 0, rd_cnt = 0, done_cnt = 0, busy_cnt = 0;
   int last_rdy_cyc = 0, start_cyc = 0, refc = 0;
   int s0 = 0, r0 = 0, frame_cnt = 0, frame_rst = 0;
   bit first_strobe = 1'b0, had_strobe = 1'b0, cur_bit = 1'b0;
   done_t e;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Synchronous pixel RAM: data one cycle after the read enable.
   always @(posedge clk_i) if (rd_en_o) rd_data_i <= ram[rd_addr_o];

   // Encoder model: end-of-bit pulse enc_lat cycles after each strobe,
   // optionally stretched one extra cycle so it overlaps the next strobe.
   always @(posedge clk_i) begin
      cyc       <= cyc + 1;
      bit_rdy_i <= (cyc + 1 == rdy_due) || (dbl && (cyc == rdy_due));
   end

   // Monitor: compares every DUT action against the queued expectations.
   always @(negedge clk_i) if (rst_n_i) begin
      if (rd_en_o) begin
         rd_cnt++;
         if (exp_addr.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_read: addr %0d, expected no read", rd_addr_o);
         end else chk("rd_addr", rd_addr_o, exp_addr.pop_front());
      end
      if (bit_rdy_i && cyc == rdy_due) begin
         last_rdy_cyc = cyc;
         chk("bit_hold", bit_data_o, cur_bit);
      end
      if (bit_vld_o) begin
         strobe_cnt++;
         if (first_strobe) chk("first_strobe_lat", cyc - start_cyc, 3);
         else chk("strobe_gap", cyc - last_rdy_cyc, 1);
         first_strobe = 1'b0;
         had_strobe   = 1'b1;
         if (exp_bits.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_strobe: bit %0d, expected no strobe", bit_data_o);
         end else begin
            cur_bit = exp_bits.pop_front();
            chk("bit_data", bit_data_o, cur_bit);
         end
         rdy_due = cyc + enc_lat;
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin
         done_cnt++;
         if (exp_done.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_done: done_o=1, expected 0");
         end else begin
            e    = exp_done.pop_front();
            refc = had_strobe ? last_rdy_cyc : start_cyc;
            chk("done_latency", cyc - refc, e.lat);
            if (e.busy >= 0) chk("busy_cycles", busy_cnt, e.busy);
         end
      end
   end

   task automatic begin_frame(input int cnt, input int rst);
      done_t d;
      for (int p = 0; p < cnt; p++) begin
         exp_addr.push_back(ADDR_W'(p));
         for (int b = PIX_W - 1; b >= 0; b--) exp_bits.push_back(ram[p][b]);
      end
      d.lat  = ((rst > 1) ? rst : 1) + 1;
      d.busy = (cnt == 0) ? d.lat + 1 : -1;
      exp_done.push_back(d);
      first_strobe = 1'b1; had_strobe = 1'b0; busy_cnt = 0;
      s0 = strobe_cnt; r0 = rd_cnt; frame_cnt = cnt; frame_rst = rst;
      @(posedge clk_i); #1;
      start_i = 1'b1; pix_cnt_i = (ADDR_W+1)'(cnt); rst_cnt_i = RST_W'(rst);
      start_cyc = cyc;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic end_frame();
      int n0, k, budget;
      n0 = done_cnt; k = 0;
      budget = frame_cnt * PIX_W * (enc_lat + 3) + frame_rst + 50;
      while (done_cnt == n0 && k < budget) begin
         @(negedge clk_i); k++;
      end
      chk("done_seen", done_cnt - n0, 1);
      repeat (3) @(negedge clk_i);
      chk("strobe_count", strobe_cnt - s0, frame_cnt * PIX_W);
      chk("read_count", rd_cnt - r0, frame_cnt);
      chk("bits_left", exp_bits.size(), 0);
      chk("reads_left", exp_addr.size(), 0);
      chk("busy_after", busy_o, 0);
   endtask

   initial begin
      int k, d0;
      // reset state
      repeat (2) @(negedge clk_i);
      chk("rst_rd_en", rd_en_o, 0);   chk("rst_rd_addr", rd_addr_o, 0);
      chk("rst_bit_vld", bit_vld_o, 0); chk("rst_bit_data", bit_data_o, 0);
      chk("rst_busy", busy_o, 0);     chk("rst_done", done_o, 0);
      @(posedge clk_i); #1 rst_n_i = 1'b1;
      repeat (2) @(posedge clk_i);

      // single pixel 0xA5F00F -> 1010_0101_1111_0000_0000_1111
      ram[0] = 24'hA5F00F; enc_lat = 10;
      begin_frame(1, 4); end_frame();

      // three pixels, boundaries gap-free
      ram[0] = 24'hFFFFFF; ram[1] = 24'h000000; ram[2] = 24'h800001; enc_lat = 3;
      begin_frame(3, 2); end_frame();

      // zero length: busy 3 cycles, done in the third
      begin_frame(0, 0); end_frame();

      // start while busy ignored; encoder pulse overlapping strobes ignored
      ram[0] = 24'h123456; ram[1] = 24'hC3A50F; enc_lat = 4; dbl = 1'b1;
      d0 = done_cnt;
      begin_frame(2, 3);
      repeat (40) @(posedge clk_i);
      #1 start_i = 1'b1; pix_cnt_i = 9'd5; rst_cnt_i = '0;
      @(posedge clk_i); #1 start_i = 1'b0;
      end_frame();
      repeat (40) @(negedge clk_i);
      chk("single_done", done_cnt - d0, 1);
      dbl = 1'b0;

      // reset during pixel 1, bit index 10 (38th strobe)
      ram[0] = 24'h123456; ram[1] = 24'hFFFFFF; ram[2] = 24'h0F0F0F; enc_lat = 3;
      begin_frame(3, 2);
      k = 0;
      while (strobe_cnt - s0 < 38 && k < 1000) begin
         @(negedge clk_i); k++;
      end
      chk("reach_bit10", strobe_cnt - s0, 38);
      @(posedge clk_i); #2 rst_n_i = 1'b0;
      #1;
      chk("mid_rst_rd_en", rd_en_o, 0);   chk("mid_rst_bit_vld", bit_vld_o, 0);
      chk("mid_rst_bit_data", bit_data_o, 0); chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_done", done_o, 0);
      exp_addr.delete(); exp_bits.delete(); exp_done.delete(); rdy_due = -100;
      repeat (2) @(posedge clk_i); #1 rst_n_i = 1'b1;
      d0 = done_cnt;
      repeat (20) @(negedge clk_i);
      chk("no_done_after_rst", done_cnt - d0, 0);
      ram[0] = 24'h5AC3E1;
      begin_frame(1, 1); end_frame();

      // max frame: 256 pixels, addresses 0..255 with no wrap
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = 8'(i);
         ram[i] = {v, ~v, v ^ 8'h3C};
      end
      enc_lat = 2;
      begin_frame(256, 7); end_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
